dec_scan: RTL

DEC_SCAN -- requirements
Module: dec_scan

---
 rtl/dec_scan.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with an auto-scan mode.
//
// Direct mode decodes a captured select value onto y. Scan mode walks y
// through indices 0..OUT_WIDTH-1, holding each one for DWELL cycles, and
// pulses wrap when the index rolls over from the last position to 0.
//
// Parameters:
//   IN_WIDTH  - select/index width
//   OUT_WIDTH - number of one-hot outputs (2 .. 2**IN_WIDTH)
//   DWELL     - cycles each output is held while scanning (1 .. 255)
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   en        - enable; low blanks y and freezes the scan
//   mode      - 0 = direct decode, 1 = auto-scan
//   load      - direct mode: capture a this cycle
//   a         - select value, or scan start index on entry to scan
//   y         - registered one-hot output (or zero)
//   idx       - registered index currently driven on y
//   err       - out-of-range flag
//   wrap      - one-cycle pulse when the scan index wraps to 0
//   dbg_state - current FSM state (0 = OFF, 1 = DIRECT, 2 = SCAN)
//
// Build option: define DEC_SCAN_STICKY_ERR_EN to make err sticky until rst.
//
// Handshake note: this block has no valid/ready pairs; load is a plain
// single-cycle strobe sampled on the rising edge while en=1 and mode=0.

module dec_scan #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8,
  parameter int DWELL     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  a,
  output logic [OUT_WIDTH-1:0] y,
  output logic [IN_WIDTH-1:0]  idx,
  output logic                 err,
  output logic                 wrap,
  output logic [1:0]           dbg_state
);

`ifdef DEC_SCAN_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [IN_WIDTH:0]   OW_L  = (IN_WIDTH+1)'(OUT_WIDTH);
  localparam logic [IN_WIDTH-1:0] LAST  = IN_WIDTH'(OUT_WIDTH - 1);
  localparam logic [7:0]          DLAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             dwell, dwell_n;
  logic [IN_WIDTH-1:0]    idx_n;
  logic [OUT_WIDTH-1:0]   y_n;
  logic                   err_n, wrap_n;
  logic                   a_ok;

  function automatic logic [OUT_WIDTH-1:0] onehot(input logic [IN_WIDTH-1:0] i);
    onehot = OUT_WIDTH'(1) << i;
  endfunction

  assign a_ok      = ({1'b0, a} < OW_L);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_OFF;
    else     state <= state_n;
  end

  // Next-state logic: en has priority over mode.
  always_comb begin
    state_n = state;
    if (!en)       state_n = S_OFF;
    else if (mode) state_n = S_SCAN;
    else           state_n = S_DIRECT;
  end

  // Next values of the registered outputs and the dwell counter.
  always_comb begin
    idx_n   = idx;
    y_n     = y;
    err_n   = err;
    wrap_n  = 1'b0;
    dwell_n = dwell;
    if (!en) begin
      y_n = '0;
    end else if (state == S_SCAN) begin
      // Leaving scan for direct keeps y/idx/counter as they are.
      if (mode) begin
        if (dwell == DLAST) begin
          dwell_n = 8'd0;
          wrap_n  = (idx == LAST);
          idx_n   = (idx == LAST) ? '0 : idx + IN_WIDTH'(1);
        end else begin
          dwell_n = dwell + 8'd1;
        end
        y_n = onehot(idx_n);
      end
    end else if (mode) begin
      if (state == S_DIRECT) begin
        // Fresh scan entry: start at a, or at 0 if a is out of range.
        dwell_n = 8'd0;
        if (a_ok) begin
          idx_n = a;
          err_n = STICKY & err;
        end else begin
          idx_n = '0;
          err_n = 1'b1;
        end
      end
      // From OFF the scan resumes at the frozen idx and counter.
      y_n = onehot(idx_n);
    end else if (load) begin
      if (a_ok) begin
        idx_n = a;
        y_n   = onehot(a);
        err_n = STICKY & err;
      end else begin
        y_n   = '0;
        err_n = 1'b1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      y     <= '0;
      err   <= 1'b0;
      wrap  <= 1'b0;
      dwell <= 8'd0;
    end else begin
      idx   <= idx_n;
      y     <= y_n;
      err   <= err_n;
      wrap  <= wrap_n;
      dwell <= dwell_n;
    end
  end

endmodule
